// File: rtl/systolic_ws_array.sv
// Weight-stationary ROWS x COLS systolic MAC array.
// A weight matrix is preloaded row by row, then input vectors stream in with a
// valid/ready handshake. Each accepted vector x produces y[c] = sum_r x[r]*W[r][c]
// a fixed ROWS+COLS cycles later. Input skew and output de-skew are internal, so
// the outside world sees whole vectors in and whole vectors out.

module systolic_ws_array #(
  parameter int WIDTH     = 8,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int ACC_WIDTH = 2*WIDTH + $clog2(ROWS)
) (
  input  logic                      CLK,
  input  logic                      SYNC_RST,
  input  logic                      W_VALID,
  input  logic [COLS*WIDTH-1:0]     W_DATA,
  output logic                      W_READY,
  input  logic                      IN_VALID,
  input  logic [ROWS*WIDTH-1:0]     IN_DATA,
  input  logic                      IN_LAST,
  output logic                      IN_READY,
  output logic                      OUT_VALID,
  output logic [COLS*ACC_WIDTH-1:0] OUT_DATA,
  output logic                      OUT_LAST,
  output logic                      BUSY
);

  localparam int CNT_W    = $clog2(ROWS);
  localparam int SKEW_N   = (ROWS*(ROWS-1))/2;
  localparam int DESKEW_N = (COLS*(COLS-1))/2;
  localparam int TOK_N    = ROWS + COLS - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_W,
    S_COMPUTE,
    S_DRAIN
  } state_t;

  // Row r owns r skew registers packed back to back; this gives the first one.
  function automatic int skew_base(input int r);
    return (r*(r-1))/2;
  endfunction

  // Column c owns COLS-1-c de-skew registers packed back to back.
  function automatic int deskew_base(input int c);
    return c*(COLS-1) - (c*(c-1))/2;
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        row_cnt_q, row_cnt_d;
  logic signed [WIDTH-1:0] w_q [ROWS][COLS];
  logic signed [WIDTH-1:0] w_d [ROWS][COLS];

  logic signed [WIDTH-1:0] skew_q [SKEW_N];
  logic signed [WIDTH-1:0] skew_d [SKEW_N];
  logic signed [WIDTH-1:0] pe_x_q [ROWS][COLS-1];
  logic signed [WIDTH-1:0] pe_x_d [ROWS][COLS-1];
  logic [ACC_WIDTH-1:0]    psum_q [ROWS][COLS];
  logic [ACC_WIDTH-1:0]    psum_d [ROWS][COLS];
  logic [ACC_WIDTH-1:0]    deskew_q [DESKEW_N];
  logic [ACC_WIDTH-1:0]    deskew_d [DESKEW_N];

  logic [TOK_N-1:0]        tok_valid_q, tok_valid_d;
  logic [TOK_N-1:0]        tok_last_q, tok_last_d;

  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic [COLS*ACC_WIDTH-1:0] out_data_q, out_data_d;

  logic                    w_fire;
  logic                    in_fire;
  logic signed [WIDTH-1:0] row_in [ROWS];
  logic signed [WIDTH-1:0] pe_in [ROWS][COLS];
  logic [ACC_WIDTH-1:0]    psum_up [ROWS][COLS];
  logic [ACC_WIDTH-1:0]    prod_ext [ROWS][COLS];
  logic [ACC_WIDTH-1:0]    col_out [COLS];

  assign W_READY   = (state_q == S_IDLE) || (state_q == S_LOAD_W);
  assign IN_READY  = (state_q == S_COMPUTE);
  assign BUSY      = (state_q != S_IDLE);
  assign w_fire    = W_VALID && W_READY;
  assign in_fire   = IN_VALID && IN_READY;
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;
  assign OUT_DATA  = out_data_q;

  // Control: weight loading sequence, batch streaming and drain tracking.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    w_d       = w_q;
    if (w_fire) begin
      for (int c = 0; c < COLS; c++) begin
        w_d[row_cnt_q][c] = W_DATA[c*WIDTH +: WIDTH];
      end
    end
    case (state_q)
      S_IDLE: begin
        if (w_fire) begin
          state_d   = S_LOAD_W;
          row_cnt_d = CNT_W'(1);
        end
      end
      S_LOAD_W: begin
        if (w_fire) begin
          if (row_cnt_q == CNT_W'(ROWS-1)) begin
            state_d   = S_COMPUTE;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + CNT_W'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (in_fire && IN_LAST) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_last_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Input skew: row r sees its element r cycles after the vector is accepted.
  always_comb begin
    skew_d    = skew_q;
    row_in    = '{default: '0};
    row_in[0] = in_fire ? IN_DATA[WIDTH-1:0] : '0;
    for (int r = 1; r < ROWS; r++) begin
      skew_d[skew_base(r)] = in_fire ? IN_DATA[r*WIDTH +: WIDTH] : '0;
      for (int k = 1; k < r; k++) begin
        skew_d[skew_base(r)+k] = skew_q[skew_base(r)+k-1];
      end
      row_in[r] = skew_q[skew_base(r)+r-1];
    end
  end

  // PE grid: x moves right and partial sums move down, one register per hop.
  always_comb begin
    pe_in    = '{default: '0};
    psum_up  = '{default: '0};
    prod_ext = '{default: '0};
    psum_d   = psum_q;
    pe_x_d   = pe_x_q;
    for (int r = 0; r < ROWS; r++) begin
      pe_in[r][0] = row_in[r];
      for (int c = 1; c < COLS; c++) begin
        pe_in[r][c] = pe_x_q[r][c-1];
      end
    end
    for (int c = 0; c < COLS; c++) begin
      psum_up[0][c] = '0;
      for (int r = 1; r < ROWS; r++) begin
        psum_up[r][c] = psum_q[r-1][c];
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        prod_ext[r][c] = ACC_WIDTH'((2*WIDTH)'(pe_in[r][c]) * (2*WIDTH)'(w_q[r][c]));
        psum_d[r][c]   = psum_up[r][c] + prod_ext[r][c];
      end
      for (int c = 0; c < COLS-1; c++) begin
        pe_x_d[r][c] = pe_in[r][c];
      end
    end
  end

  // Output de-skew: early columns wait so all columns of a vector line up.
  always_comb begin
    deskew_d = deskew_q;
    col_out  = '{default: '0};
    for (int c = 0; c < COLS-1; c++) begin
      deskew_d[deskew_base(c)] = psum_q[ROWS-1][c];
      for (int k = 1; k < COLS-1-c; k++) begin
        deskew_d[deskew_base(c)+k] = deskew_q[deskew_base(c)+k-1];
      end
      col_out[c] = deskew_q[deskew_base(c)+COLS-2-c];
    end
    col_out[COLS-1] = psum_q[ROWS-1][COLS-1];
  end

  // Valid/last tokens shadow each vector through the array; output register holds.
  always_comb begin
    tok_valid_d = {tok_valid_q[TOK_N-2:0], in_fire};
    tok_last_d  = {tok_last_q[TOK_N-2:0], in_fire && IN_LAST};
    out_valid_d = tok_valid_q[TOK_N-1];
    out_last_d  = tok_valid_q[TOK_N-1] && tok_last_q[TOK_N-1];
    out_data_d  = out_data_q;
    if (tok_valid_q[TOK_N-1]) begin
      for (int c = 0; c < COLS; c++) begin
        out_data_d[c*ACC_WIDTH +: ACC_WIDTH] = col_out[c];
      end
    end
  end

  // State registers; reset wipes weights and every in-flight result.
  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      state_q     <= S_IDLE;
      row_cnt_q   <= '0;
      w_q         <= '{default: '0};
      skew_q      <= '{default: '0};
      pe_x_q      <= '{default: '0};
      psum_q      <= '{default: '0};
      deskew_q    <= '{default: '0};
      tok_valid_q <= '0;
      tok_last_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      w_q         <= w_d;
      skew_q      <= skew_d;
      pe_x_q      <= pe_x_d;
      psum_q      <= psum_d;
      deskew_q    <= deskew_d;
      tok_valid_q <= tok_valid_d;
      tok_last_q  <= tok_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
